// File: rtl/keycode_cmd.sv
// Debounces the HID keycode from the SoC PIO and turns it into press and
// auto-repeat game commands, delivered one at a time over valid/ready.
module keycode_cmd #(
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_RATE   = 5_000_000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] keycode,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       cmd_repeat,
  output logic [3:0] held_dir,
  output logic [7:0] drop_cnt
);

  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW = (TMAX > 0) ? $clog2(TMAX + 1) : 1;
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HOLD} state_t;
  typedef enum logic [2:0] {
    CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT, CMD_CONFIRM, CMD_CANCEL, CMD_START
  } cmd_t;

  // Returns {mapped, code}; mapped=0 means "none".
  function automatic logic [3:0] map_key(input logic [7:0] kc);
    case (kc)
      8'h1A:   map_key = {1'b1, CMD_UP};
      8'h16:   map_key = {1'b1, CMD_DOWN};
      8'h04:   map_key = {1'b1, CMD_LEFT};
      8'h07:   map_key = {1'b1, CMD_RIGHT};
      8'h2C:   map_key = {1'b1, CMD_CONFIRM};
      8'h29:   map_key = {1'b1, CMD_CANCEL};
      8'h28:   map_key = {1'b1, CMD_START};
      default: map_key = 4'b0000;
    endcase
  endfunction

  logic [7:0]    kc_q, kc_acc;
  logic [SW-1:0] stab_cnt;
  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [2:0]    cur_code, cur_next;
  logic          acc_hit, acc_dir, press_ev, rpt_ev, blocked, load_ev;
  logic [2:0]    acc_code;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      kc_q     <= '0;
      stab_cnt <= '0;
      kc_acc   <= '0;
    end else begin
      kc_q <= keycode;
      if (keycode != kc_q)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_LAST)
        stab_cnt <= stab_cnt + 1'b1;
      if (stab_cnt == STAB_LAST)
        kc_acc <= kc_q;
    end
  end

  assign {acc_hit, acc_code} = map_key(kc_acc);
  assign acc_dir = acc_hit && !acc_code[2];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= IDLE;
      timer    <= '0;
      cur_code <= '0;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      cur_code <= cur_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    timer_next = timer;
    cur_next   = cur_code;
    if (!acc_hit) begin
      state_next = IDLE;
      timer_next = '0;
    end else if (press_ev) begin
      cur_next = acc_code;
      if (acc_dir) begin
        state_next = DELAY;
        timer_next = TW'(REPEAT_DELAY);
      end else begin
        state_next = HOLD;
        timer_next = '0;
      end
    end else if (rpt_ev) begin
      state_next = REPEAT;
      timer_next = TW'(REPEAT_RATE);
    end else if (state == DELAY || state == REPEAT) begin
      timer_next = timer - 1'b1;
    end
  end

  // A change of mapped key always presses; repeats only fire while a direction is held.
  always_comb begin
    press_ev = 1'b0;
    rpt_ev   = 1'b0;
    if (acc_hit) begin
      if (state == IDLE || acc_code != cur_code)
        press_ev = 1'b1;
      else if ((state == DELAY || state == REPEAT) && timer == '0)
        rpt_ev = 1'b1;
    end
  end

  // A press may overwrite a stalled entry; a repeat may not.
  assign blocked = cmd_valid && !cmd_ready;
  assign load_ev = press_ev || (rpt_ev && !blocked);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cmd_valid  <= 1'b0;
      cmd_code   <= '0;
      cmd_repeat <= 1'b0;
      held_dir   <= '0;
      drop_cnt   <= '0;
    end else begin
      if (load_ev) begin
        cmd_valid  <= 1'b1;
        cmd_code   <= acc_code;
        cmd_repeat <= !press_ev;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
      if (rpt_ev && blocked && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      held_dir <= acc_dir ? (4'b0001 << acc_code[1:0]) : 4'b0000;
    end
  end

endmodule

// File: tb/tb_keycode_cmd.sv
// Self-checking bench for keycode_cmd: directed scenarios plus randomized key
// streams compared every cycle against a timestamp-based behavioural model.
module tb_keycode_cmd;

  localparam int STABLE = 4;
  localparam int DELAY  = 20;
  localparam int RATE   = 8;

  logic       clk;
  logic       rst_n;
  logic [7:0] keycode;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic       cmd_repeat;
  logic [3:0] held_dir;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  keycode_cmd #(
    .STABLE_CYCLES(STABLE),
    .REPEAT_DELAY (DELAY),
    .REPEAT_RATE  (RATE)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .keycode      (keycode),
    .cmd_ready    (cmd_ready),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .cmd_repeat   (cmd_repeat),
    .held_dir     (held_dir),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Accepted key = last input that stayed put for STABLE sampled cycles;
  // repeat instants are computed arithmetically from the press timestamp.
  logic [7:0] hist[$];
  logic [7:0] m_acc;
  bit         m_active;
  int         m_cur;
  int         m_press_t;
  int         n_edge;
  bit         m_v;
  logic [2:0] m_code;
  bit         m_rpt;
  int         m_drop;
  logic [3:0] m_held;

  function automatic int map_cmd(input logic [7:0] kc);
    case (kc)
      8'h1A: return 0;
      8'h16: return 1;
      8'h04: return 2;
      8'h07: return 3;
      8'h2C: return 4;
      8'h29: return 5;
      8'h28: return 6;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(8'h00);
    m_acc = 8'h00; m_active = 0; m_cur = 0; m_press_t = 0; n_edge = 0;
    m_v = 0; m_code = 3'd0; m_rpt = 0; m_drop = 0; m_held = 4'd0;
  endtask

  task automatic model_step();
    int  c;
    int  age;
    bit  press;
    bit  rep;
    bit  stalled;
    n_edge++;
    c = map_cmd(m_acc);
    press = 0;
    rep = 0;
    if (c < 0) begin
      m_active = 0;
    end else if (!m_active || c != m_cur) begin
      press = 1; m_active = 1; m_cur = c; m_press_t = n_edge;
    end else if (c < 4) begin
      age = n_edge - m_press_t - (DELAY + 1);
      if (age >= 0 && (age % (RATE + 1)) == 0) rep = 1;
    end
    stalled = m_v && !cmd_ready;
    if (press) begin
      m_v = 1; m_code = 3'(c); m_rpt = 0;
    end else if (rep && !stalled) begin
      m_v = 1; m_code = 3'(c); m_rpt = 1;
    end else if (m_v && cmd_ready) begin
      m_v = 0;
    end
    if (rep && stalled && m_drop < 255) m_drop++;
    m_held = (c >= 0 && c < 4) ? 4'(1 << c) : 4'd0;
    if (hist.size() == STABLE && hist[0] == hist[1] && hist[1] == hist[2] && hist[2] == hist[3])
      m_acc = hist[$];
    hist.push_back(keycode);
    if (hist.size() > STABLE) void'(hist.pop_front());
  endtask

  // One clock: advance, then sample 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_step();
    check("m_valid", cmd_valid, m_v);
    if (m_v) begin
      check("m_code", cmd_code, m_code);
      check("m_repeat", cmd_repeat, m_rpt);
    end
    check("m_held", held_dir, m_held);
    check("m_drop", drop_cnt, m_drop);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", cmd_valid, 0);
    check("rst_code", cmd_code, 0);
    check("rst_repeat", cmd_repeat, 0);
    check("rst_held", held_dir, 0);
    check("rst_drop", drop_cnt, 0);
    model_reset();
    cycle();
    cycle();
  endtask

  task automatic start(input logic [7:0] kc, input logic rdy);
    do_reset();
    keycode   = kc;
    cmd_ready = rdy;
    rst_n     = 1'b1;
  endtask

  initial begin
    int rises[$];
    int cnt;
    int held_seen;
    int exp_t[4];
    int hold_left;
    int ready_pct;
    int pick;
    logic [7:0] keys[8];

    rst_n = 1'b0; keycode = 8'h00; cmd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Press: single UP command at +6, then dropped by ready.
    start(8'h1A, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      cycle();
      check("press_valid", cmd_valid, 32'(k == 6));
      if (k == 6) begin
        check("press_code", cmd_code, 0);
        check("press_rep", cmd_repeat, 0);
        check("press_held", held_dir, 4'b0001);
      end
    end

    // Auto-repeat on RIGHT.
    start(8'h07, 1'b1);
    rises.delete();
    exp_t = '{6, 27, 36, 45};
    for (int k = 1; k <= 50; k++) begin
      cycle();
      if (cmd_valid) begin
        rises.push_back(k);
        check("ar_code", cmd_code, 3);
        check("ar_flag", cmd_repeat, 32'(k != 6));
      end
    end
    check("ar_count", rises.size(), 4);
    for (int i = 0; i < 4 && i < rises.size(); i++) check("ar_time", rises[i], exp_t[i]);

    // Button: one CONFIRM, no direction.
    start(8'h2C, 1'b1);
    cnt = 0; held_seen = 0;
    for (int k = 1; k <= 60; k++) begin
      cycle();
      if (cmd_valid) begin
        cnt++;
        check("btn_code", cmd_code, 4);
      end
      if (held_dir != 0) held_seen++;
    end
    check("btn_count", cnt, 1);
    check("btn_held", held_seen, 0);

    // Glitch shorter than the stability window.
    start(8'h16, 1'b1);
    cnt = 0; held_seen = 0;
    for (int k = 1; k <= 23; k++) begin
      if (k == 4) keycode = 8'h00;
      cycle();
      if (cmd_valid) cnt++;
      if (held_dir != 0) held_seen++;
    end
    check("glitch_valid", cnt, 0);
    check("glitch_held", held_seen, 0);

    // Backpressure: stalled LEFT press, repeats discarded.
    start(8'h04, 1'b0);
    for (int k = 1; k <= 36; k++) begin
      cycle();
      if (k == 35) check("bp_drop1", drop_cnt, 1);
    end
    check("bp_valid", cmd_valid, 1);
    check("bp_code", cmd_code, 2);
    check("bp_rep", cmd_repeat, 0);
    check("bp_drop2", drop_cnt, 2);

    // Drop counter saturation.
    start(8'h1A, 1'b0);
    for (int k = 1; k <= 2400; k++) cycle();
    check("drop_sat", drop_cnt, 255);

    // Key switch, then reset mid-hold, then re-press after release.
    start(8'h1A, 1'b1);
    rises.delete();
    for (int k = 1; k <= 30; k++) begin
      if (k == 11) keycode = 8'h28;
      cycle();
      if (cmd_valid) begin
        rises.push_back(k);
        if (k == 16) begin
          check("sw_code", cmd_code, 6);
          check("sw_rep", cmd_repeat, 0);
        end
      end
    end
    check("sw_count", rises.size(), 2);
    if (rises.size() == 2) check("sw_time", rises[1], 16);
    do_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      check("rr_valid", cmd_valid, 32'(k == 6));
      if (k == 6) check("rr_code", cmd_code, 6);
    end

    // Randomized key streams with varying consumer readiness.
    keys = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C, 8'h29, 8'h28, 8'h00};
    start(8'h00, 1'b1);
    hold_left = 0;
    ready_pct = 100;
    for (int i = 0; i < 6000; i++) begin
      if (hold_left == 0) begin
        pick = $urandom_range(0, 9);
        keycode = (pick < 8) ? keys[pick] : 8'($urandom);
        hold_left = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 120) : $urandom_range(1, 12);
        case ($urandom_range(0, 3))
          0: ready_pct = 0;
          1: ready_pct = 50;
          2: ready_pct = 90;
          default: ready_pct = 100;
        endcase
      end
      hold_left--;
      cmd_ready = ($urandom_range(0, 99) < ready_pct);
      if ($urandom_range(0, 1999) == 0) begin
        do_reset();
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keycode_cmd.md
# keycode_cmd

Converts the 8-bit USB HID keycode published by the Nios II SoC's keycode PIO into debounced, auto-repeating game commands for the overworld/battle logic. Sits directly downstream of the SoC `keycode_export` output and upstream of the game-state engine. Delivers one command at a time over a valid/ready handshake.

## Interface
- `STABLE_CYCLES`, 1000: consecutive identical samples required before a keycode is accepted.
- `REPEAT_DELAY`, 25_000_000: cycles from a direction press's command to its first repeat.
- `REPEAT_RATE`, 5_000_000: cycles between subsequent repeats.
- `clk_clk`, in, 1: system clock, 50 MHz.
- `reset_reset_n`, in, 1: asynchronous, active-low reset.
- `keycode`, in, 8: raw HID keycode from the SoC; 0x00 means no key.
- `cmd_ready`, in, 1: consumer accepts the command this cycle.
- `cmd_valid`, out, 1: a command is pending.
- `cmd_code`, out, 3: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 CONFIRM, 5 CANCEL, 6 START.
- `cmd_repeat`, out, 1: pending command was generated by auto-repeat.
- `held_dir`, out, 4: one-hot level of the accepted direction key, {RIGHT, LEFT, DOWN, UP}.
- `drop_cnt`, out, 8: saturating count of discarded repeat events.

## Operation
- Key map:
  - 0x1A (W) → UP, 0x16 (S) → DOWN, 0x04 (A) → LEFT, 0x07 (D) → RIGHT.
  - 0x2C (Space) → CONFIRM, 0x29 (Esc) → CANCEL, 0x28 (Enter) → START.
  - Every other value, including 0x00, is "none".
- Input stage:
  - `keycode` is registered into `kc_q`.
  - A stability counter reloads whenever `kc_q` changes.
  - When `kc_q` has held one value for `STABLE_CYCLES` consecutive cycles, it is copied into `kc_acc` (the accepted keycode).
- FSM states: IDLE, DELAY, REPEAT, HOLD.
  - IDLE: `kc_acc` becomes a mapped key → emit a press event.
    - Direction key → DELAY, timer loaded with `REPEAT_DELAY`.
    - Button key → HOLD.
  - DELAY / REPEAT: timer decrements each cycle. At 0, emit a repeat event, reload the timer with `REPEAT_RATE`, go to REPEAT.
  - HOLD: no repeats.
  - Any state: `kc_acc` changes to a different mapped key → emit a press event for the new key and enter DELAY or HOLD accordingly. The timer reloads.
  - Any state: `kc_acc` changes to "none" → IDLE. No event is emitted.
- Output register (one entry):
  - An event sets `cmd_valid`, `cmd_code`, and `cmd_repeat` (0 for a press, 1 for a repeat).
  - Cleared on `cmd_valid && cmd_ready` unless a new event is loaded in the same cycle; in that case the new event is loaded and `cmd_valid` stays 1.
- Pending-entry conflicts (`cmd_valid && !cmd_ready` when a new event arrives):
  - Press event: overwrites the pending entry.
  - Repeat event: discarded and `drop_cnt` increments, saturating at 255. The timer still reloads.
- `held_dir` reflects the mapped direction of `kc_acc`, or 0 if `kc_acc` is not a direction.

## Timing
- Reset values: `cmd_valid`=0, `cmd_code`=0, `cmd_repeat`=0, `held_dir`=0, `drop_cnt`=0.
- Reset internals: `kc_q`=0, `kc_acc`=0, FSM=IDLE, timers=0.
- Latency from a `keycode` change to `cmd_valid` high: `STABLE_CYCLES` + 2 cycles, provided the value is held.
- `held_dir` updates in the same cycle `cmd_valid` rises.
- First repeat: `cmd_valid` rises `REPEAT_DELAY` + 1 cycles after the press `cmd_valid` rise. Later repeats are spaced `REPEAT_RATE` + 1 cycles apart.
- A glitch shorter than `STABLE_CYCLES` is fully ignored; the counter restarts on the return value.
- Reset asserted mid-operation clears all state immediately. Outputs return to reset values asynchronously.
- A pending command is lost on reset.
- `cmd_ready` while `cmd_valid`=0 has no effect.

## Test plan
Parameters for all scenarios: `STABLE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_RATE`=8.
- Press: `keycode`=0x1A held, `cmd_ready`=1 → `cmd_valid` for 1 cycle at +6 cycles with `cmd_code`=0, `cmd_repeat`=0; `held_dir`=4'b0001.
- Auto-repeat: hold 0x07 for 60 cycles, `cmd_ready`=1 → press (code 3), then repeats at +21, +30, +39 cycles after the press, each with `cmd_repeat`=1.
- Button press: hold 0x2C for 60 cycles → exactly one command, code 4; `held_dir`=0.
- Glitch rejection: 0x16 for 3 cycles, then 0x00 → no `cmd_valid`; `held_dir` stays 0.
- Backpressure: hold 0x04, `cmd_ready`=0 throughout → `cmd_valid` stays high with code 2, `cmd_repeat`=0; `drop_cnt` reaches 2 by +30 cycles.
- Key switch and reset:
  - 0x1A held, then 0x28 → new press, code 6, before any repeat.
  - Then `reset_reset_n`=0 mid-hold → all outputs 0 within the reset cycle.
  - After release of reset, with 0x28 still present → new press at +6 cycles.
